// File: rtl/vam_pkg.sv
// vam_pkg: shared definitions for the approximate-multiply controller.
//   vam_state_t  : controller state encoding
//   VAM_W_DEF    : default operand width
//   VAM_K_DEF    : default segment width of the external KxK multiplier
package vam_pkg;

    localparam int VAM_W_DEF = 16;
    localparam int VAM_K_DEF = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        ISSUE = 3'd2,
        CAP   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } vam_state_t;

endpackage

// File: rtl/vam_lod.sv
// vam_lod: per-operand leading-one scan for segment selection.
// The index starts at W-1 and walks down one bit per cycle while scanning.
// It stops on a set bit, or on reaching K-1. When the operand's upper part
// (bits W-1..K) is all zero, the whole operand fits in one segment: the index
// snaps to K-1 and reports stopped straight away.
// Ports:
//   clk, rst  : clock, asynchronous active-low reset
//   load      : start accepted; preset index to W-1
//   scan      : controller is in SCAN; advance index when not stopped
//   op        : latched operand
//   idx       : current index (segment MSB position)
//   stopped   : index has reached its final position
import vam_pkg::*;

module vam_lod #(
    parameter int  W  = VAM_W_DEF,
    parameter int  K  = VAM_K_DEF,
    localparam int IW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          scan,
    input  logic [W-1:0]  op,
    output logic [IW-1:0] idx,
    output logic          stopped
);

    localparam logic [IW-1:0] IDX_TOP = IW'(W - 1);
    localparam logic [IW-1:0] IDX_MIN = IW'(K - 1);

    logic [IW-1:0] idx_reg;
    logic          hi_zero;

    assign hi_zero = (op[W-1:K] == '0);
    assign stopped = hi_zero || op[idx_reg] || (idx_reg == IDX_MIN);
    assign idx     = idx_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg <= '0;
        end else if (load) begin
            idx_reg <= IDX_TOP;
        end else if (scan) begin
            // A small operand uses the lowest segment regardless of where the
            // scan currently sits.
            if (hi_zero) begin
                idx_reg <= IDX_MIN;
            end else if (!stopped) begin
                idx_reg <= idx_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vam_ctrl_param.sv
// vam_ctrl_param: controller for an approximate W x W unsigned multiply. It
// uses one external registered K x K multiplier.
// Each operand is reduced to a K-bit segment that starts at its leading one.
// With rnd set, the segment LSB is forced high when lower bits were dropped.
// The K x K product is then shifted left by the total truncation amount.
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   start          : request pulse, honoured only in IDLE
//   rnd            : 0 truncate, 1 force LSB of truncated segments
//   op_a, op_b     : W-bit unsigned operands
//   seg_a, seg_b   : K-bit segments to the external multiplier (ISSUE..CAP)
//   prod           : 2K-bit product, one cycle after segments are presented
//   result         : 2W-bit approximate product, held until the next DONE
//   busy           : high outside IDLE
//   done           : one-cycle pulse when result updates
import vam_pkg::*;

module vam_ctrl_param #(
    parameter int W = VAM_W_DEF,
    parameter int K = VAM_K_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           rnd,
    input  logic [W-1:0]   op_a,
    input  logic [W-1:0]   op_b,
    output logic [K-1:0]   seg_a,
    output logic [K-1:0]   seg_b,
    input  logic [2*K-1:0] prod,
    output logic [2*W-1:0] result,
    output logic           busy,
    output logic           done
);

    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] IDX_MIN = IW'(K - 1);

    vam_state_t     state_reg, state_next;
    logic [W-1:0]   op_a_reg, op_b_reg;
    logic           rnd_reg;
    logic [2*W-1:0] work_reg, work_next;
    logic [2*W-1:0] result_reg;
    logic [IW:0]    cnt_reg, cnt_next;

    logic [IW-1:0]  ia, ib;
    logic           stop_a, stop_b;
    logic           load, scan;
    logic [IW-1:0]  sa, sb;
    logic [IW:0]    shift_total;
    logic [K-1:0]   seg_a_val, seg_b_val;
    logic           show_seg;

    assign load = (state_reg == IDLE) && start;
    assign scan = (state_reg == SCAN);

    vam_lod #(.W(W), .K(K)) u_lod_a (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .scan    (scan),
        .op      (op_a_reg),
        .idx     (ia),
        .stopped (stop_a)
    );

    vam_lod #(.W(W), .K(K)) u_lod_b (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .scan    (scan),
        .op      (op_b_reg),
        .idx     (ib),
        .stopped (stop_b)
    );

    // Once scanning ends, the indices are at least K-1. The subtraction
    // therefore only wraps in states where the segments are gated off.
    assign sa          = ia - IDX_MIN;
    assign sb          = ib - IDX_MIN;
    assign shift_total = {1'b0, sa} + {1'b0, sb};

    // Segment select is an OR of the LSB: the rounding only ever sets it.
    assign seg_a_val = op_a_reg[ia -: K] | {{(K-1){1'b0}}, (rnd_reg && (sa != '0))};
    assign seg_b_val = op_b_reg[ib -: K] | {{(K-1){1'b0}}, (rnd_reg && (sb != '0))};

    // Indices and operands are static in ISSUE and CAP, so the segments stay
    // stable across the registered multiplier's capture edge.
    assign show_seg = (state_reg == ISSUE) || (state_reg == CAP);
    assign seg_a    = show_seg ? seg_a_val : '0;
    assign seg_b    = show_seg ? seg_b_val : '0;

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

    always_comb begin
        state_next = state_reg;
        work_next  = work_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    cnt_next   = '0;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (stop_a && stop_b) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = CAP;
            end
            CAP: begin
                work_next = {{(2*W-2*K){1'b0}}, prod};
                if (shift_total != '0) begin
                    state_next = SHIFT;
                end else begin
                    state_next = DONE;
                end
            end
            SHIFT: begin
                work_next = work_reg << 1;
                cnt_next  = cnt_reg + 1'b1;
                if (cnt_next == shift_total) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            rnd_reg    <= 1'b0;
            work_reg   <= '0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            work_reg  <= work_next;
            cnt_reg   <= cnt_next;
            if (load) begin
                op_a_reg <= op_a;
                op_b_reg <= op_b;
                rnd_reg  <= rnd;
            end
            // The result register only moves on entry to DONE. It keeps the
            // previous answer visible while the next operation is running.
            if (state_next == DONE) begin
                result_reg <= work_next;
            end
        end
    end

endmodule

// File: doc/vam_ctrl_param.md
VAM_CTRL_PARAM -- requirements
Module: vam_ctrl_param

Interface
REQ-001 Parameter W, default 16, operand width; W >= K+1.
REQ-002 Parameter K, default 8, segment width fed to external KxK multiplier; K >= 2.
REQ-003 clk  input  1  clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request pulse, sampled only in IDLE.
REQ-006 rnd  input  1  0 = truncate segments, 1 = force segment LSB to 1 when that operand was truncated.
REQ-007 op_a, op_b  input  W  unsigned operands, sampled on the edge that accepts start.
REQ-008 seg_a, seg_b  output  K  segments driven to external multiplier.
REQ-009 prod  input  2K  external product, valid one cycle after seg_a/seg_b are presented (registered multiplier).
REQ-010 result  output  2W  approximate product.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when result becomes valid.

Function
REQ-013 States SHALL be IDLE, SCAN, ISSUE, CAP, SHIFT, DONE; encoding is a shared enum.
REQ-014 IDLE: start=1 latches op_a, op_b, rnd; sets indices ia=ib=W-1; clears shift counter; moves to SCAN.
REQ-015 SCAN: each index stops when op[idx]=1, idx=K-1, or op[W-1:K]=0; otherwise it decrements by one per cycle; both indices scan concurrently.
REQ-016 SCAN exits to ISSUE on the cycle in which both indices have stopped; SCAN lasts max(da,db)+1 cycles, da = 0 if pa<K else W-1-pa, with pa = leading-one position of op_a (pb/db likewise).
REQ-017 Shift amounts: sa = ia-(K-1), sb = ib-(K-1); range 0..W-K each.
REQ-018 ISSUE: seg_a = op_a[ia -: K], seg_b = op_b[ib -: K]; if rnd=1 and sa>0, seg_a[0]=1 (same rule for seg_b with sb).
REQ-019 seg_a/seg_b SHALL hold their values from ISSUE through CAP and read 0 in all other states.
REQ-020 CAP: prod zero-extended to 2W is loaded into the working register; go to SHIFT if sa+sb>0, else DONE.
REQ-021 SHIFT: working register shifts left one bit per cycle, counter increments; go to DONE when counter reaches sa+sb.
REQ-022 DONE: result = working register; done=1 for exactly one cycle; go to IDLE.
REQ-023 Latency: done is high max(da,db)+sa+sb+3 cycles after the edge accepting start.
REQ-024 result SHALL hold its value until the DONE state of the next operation.
REQ-025 start outside IDLE, including the DONE cycle, SHALL be ignored without altering state or latched operands.
REQ-026 A zero operand SHALL yield result 0 with sa or sb = 0 and no special state.
REQ-027 Working width 2W SHALL never overflow, since prod < 2^(2K) and sa+sb <= 2(W-K).

Reset
REQ-028 rst=0 SHALL force IDLE immediately, including mid-operation.
REQ-029 Reset values: busy=0, done=0, result=0, seg_a=0, seg_b=0, all counters and indices 0.
REQ-030 The first operation after reset release SHALL behave identically to any later operation.

Structure
REQ-031 Package vam_pkg SHALL hold the state enum and the default W and K constants.
REQ-032 One sub-module vam_lod SHALL implement the per-operand index scan/stop logic, instantiated twice.
REQ-033 The KxK multiplier SHALL be external to this block.

Verification (W=16, K=8, registered multiplier model)
REQ-034 a=0x0003, b=0x0005, rnd=0 -> result 0x0000000F; done 3 cycles after start.
REQ-035 a=0x8000, b=0x8000 -> seg 0x80/0x80, result 0x40000000; done 19 cycles after start.
REQ-036 a=0x0101, b=0x0003, rnd=0 -> seg_a=0x80, result 0x300, latency 11; with rnd=1 -> seg_a=0x81, result 0x306.
REQ-037 a=0x0000, b=0xFFFF -> result 0; start re-pulsed while busy -> ignored, exactly one done.
REQ-038 rst=0 asserted during SHIFT -> busy, done, result at 0 immediately; next start a=2, b=3 -> result 6.
